// File: rtl/stepdown_pkg.sv
// Shared types and constants for the step-down converter core-state sequencer.
package stepdown_pkg;

    localparam int SS_RAMP_W = 8;
    localparam int DT_W      = 4;

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_SOFTSTART = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_e;

    function automatic logic is_active(state_e s);
        return (s == ST_SOFTSTART) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/stepdown_deadtime.sv
// Break-before-make gate driver: both gates low for DT_CYCLES after any gp edge.
module stepdown_deadtime
    import stepdown_pkg::*;
#(
    parameter int DT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic gp,
    input  logic force_off,
    output logic hs_on,
    output logic ls_on
);

    logic            gp_prev_q, gp_prev_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            hs_q, hs_d;
    logic            ls_q, ls_d;

    // force_off only masks the gates; the dead-time count keeps running
    always_comb begin
        gp_prev_d = gp;
        cnt_d     = cnt_q;
        hs_d      = 1'b0;
        ls_d      = 1'b0;
        if (gp != gp_prev_q) begin
            cnt_d = DT_W'(DT_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (!force_off) begin
            hs_d = gp;
            ls_d = !gp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gp_prev_q <= 1'b0;
            cnt_q     <= '0;
            hs_q      <= 1'b0;
            ls_q      <= 1'b0;
        end else begin
            gp_prev_q <= gp_prev_d;
            cnt_q     <= cnt_d;
            hs_q      <= hs_d;
            ls_q      <= ls_d;
        end
    end

    assign hs_on = hs_q;
    assign ls_on = ls_q;

endmodule

// File: rtl/stepdown_corestate_seq.sv
// Step-down converter state sequencer: OFF/SOFTSTART/RUN/FAULT with gate dead-time.
// Define STEPDOWN_AUTORETRY_EN to leave FAULT automatically after RETRY_CYCLES.
module stepdown_corestate_seq
    import stepdown_pkg::*;
#(
    parameter int SS_CYCLES    = 1024,
    parameter int DT_CYCLES    = 4,
    parameter int RETRY_CYCLES = 4096
) (
    input  logic                 CELCLK,
    input  logic                 CELRSTB,
    input  logic                 CELV,
    input  logic                 CELG,
    input  logic                 SUB,
    input  logic                 en,
    input  logic                 pgood_in,
    input  logic                 ocp,
    input  logic                 pwm,
    output logic                 hs_on,
    output logic                 ls_on,
    output logic [1:0]           o_state,
    output logic [SS_RAMP_W-1:0] ss_ramp,
    output logic                 fault
);

    localparam int SS_W = $clog2(SS_CYCLES);

    state_e               state_q, state_d;
    logic [SS_W-1:0]      ss_cnt_q, ss_cnt_d;
    logic [SS_RAMP_W-1:0] ss_ramp_q, ss_ramp_d;
    logic                 fault_q, fault_d;
    logic                 gp;
    logic                 force_off;
    logic                 unused_pins;

`ifdef STEPDOWN_AUTORETRY_EN
    localparam int RT_W = $clog2(RETRY_CYCLES + 1);
    logic [RT_W-1:0] retry_q, retry_d;
`else
    localparam int unused_retry = RETRY_CYCLES;
`endif

    assign unused_pins = CELV ^ CELG ^ SUB;

    always_comb begin
        state_d  = state_q;
        ss_cnt_d = '0;
`ifdef STEPDOWN_AUTORETRY_EN
        retry_d  = '0;
`endif
        unique case (state_q)
            ST_OFF: begin
                if (en && pgood_in) state_d = ST_SOFTSTART;
            end
            ST_SOFTSTART, ST_RUN: begin
                if (ocp) begin
                    state_d = ST_FAULT;
                end else if (!en || !pgood_in) begin
                    state_d = ST_OFF;
                end else if (state_q == ST_SOFTSTART) begin
                    ss_cnt_d = ss_cnt_q + 1'b1;
                    if (ss_cnt_q == SS_W'(SS_CYCLES - 1)) state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
`ifdef STEPDOWN_AUTORETRY_EN
                if (!en) begin
                    state_d = ST_OFF;
                end else if (retry_q == RT_W'(RETRY_CYCLES - 1)) begin
                    state_d = pgood_in ? ST_SOFTSTART : ST_OFF;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
`else
                if (!en) state_d = ST_OFF;
`endif
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Registered outputs track the state being entered this edge
    always_comb begin
        ss_ramp_d = '0;
        if (state_d == ST_SOFTSTART) ss_ramp_d = ss_cnt_d[SS_W-1 -: SS_RAMP_W];
        else if (state_d == ST_RUN)  ss_ramp_d = '1;
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge CELCLK or negedge CELRSTB) begin
        if (!CELRSTB) begin
            state_q   <= ST_OFF;
            ss_cnt_q  <= '0;
            ss_ramp_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ss_cnt_q  <= ss_cnt_d;
            ss_ramp_q <= ss_ramp_d;
            fault_q   <= fault_d;
        end
    end

`ifdef STEPDOWN_AUTORETRY_EN
    always_ff @(posedge CELCLK or negedge CELRSTB) begin
        if (!CELRSTB) retry_q <= '0;
        else          retry_q <= retry_d;
    end
`endif

    // Gates drop on the same edge the sequencer leaves SOFTSTART/RUN
    assign gp        = pwm && is_active(state_q);
    assign force_off = !is_active(state_d);

    stepdown_deadtime #(
        .DT_CYCLES(DT_CYCLES)
    ) u_deadtime (
        .clk      (CELCLK),
        .rst_n    (CELRSTB),
        .gp       (gp),
        .force_off(force_off),
        .hs_on    (hs_on),
        .ls_on    (ls_on)
    );

    assign o_state = state_q;
    assign ss_ramp = ss_ramp_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_stepdown_corestate_seq.sv
// Randomized bench for stepdown_corestate_seq against a cycle-level behavioural model.
module tb_stepdown_corestate_seq;

    localparam int SS = 256;
    localparam int DT = 4;
    localparam int RT = 16;

    logic       CELCLK = 1'b0;
    logic       CELRSTB = 1'b0;
    logic       CELV = 1'b1;
    logic       CELG = 1'b0;
    logic       SUB = 1'b0;
    logic       en = 1'b0;
    logic       pgood_in = 1'b0;
    logic       ocp = 1'b0;
    logic       pwm = 1'b0;
    logic       hs_on, ls_on, fault;
    logic [1:0] o_state;
    logic [7:0] ss_ramp;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int m_state, m_age, m_fage, m_hs, m_ls, m_ramp;
    int hist[$];

    stepdown_corestate_seq #(
        .SS_CYCLES(SS),
        .DT_CYCLES(DT),
        .RETRY_CYCLES(RT)
    ) dut (
        .CELCLK(CELCLK), .CELRSTB(CELRSTB),
        .CELV(CELV), .CELG(CELG), .SUB(SUB),
        .en(en), .pgood_in(pgood_in), .ocp(ocp), .pwm(pwm),
        .hs_on(hs_on), .ls_on(ls_on), .o_state(o_state),
        .ss_ramp(ss_ramp), .fault(fault)
    );

    always #5 CELCLK = ~CELCLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_age = 0; m_fage = 0;
        m_hs = 0; m_ls = 0; m_ramp = 0;
        hist = {};
        repeat (DT + 1) hist.push_back(0);
    endtask

    // one rising edge of the specified behaviour
    task automatic model_clock();
        int  ns;
        int  gp;
        bit  settled;
        bit  act;
        gp = (pwm && (m_state == 1 || m_state == 2)) ? 1 : 0;
        ns = m_state;
        case (m_state)
            0: if (en && pgood_in) ns = 1;
            1, 2: begin
                if (ocp) ns = 3;
                else if (!en || !pgood_in) ns = 0;
                else if (m_state == 1) begin
                    m_age++;
                    if (m_age == SS) ns = 2;
                end
            end
            default: begin
`ifdef STEPDOWN_AUTORETRY_EN
                if (!en) ns = 0;
                else begin
                    m_fage++;
                    if (m_fage == RT) ns = pgood_in ? 1 : 0;
                end
`else
                if (!en) ns = 0;
`endif
            end
        endcase
        if (ns == 1 && m_state != 1) m_age = 0;
        if (ns == 3 && m_state != 3) m_fage = 0;
        m_state = ns;
        hist.push_back(gp);
        void'(hist.pop_front());
        settled = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) settled = 1'b0;
        act = (m_state == 1 || m_state == 2);
        m_hs = (act && settled && hist[DT] == 1) ? 1 : 0;
        m_ls = (act && settled && hist[DT] == 0) ? 1 : 0;
        m_ramp = (m_state == 1) ? m_age / (SS / 256) :
                 (m_state == 2) ? 255 : 0;
    endtask

    task automatic compare();
        check("o_state", o_state, m_state);
        check("fault", fault, (m_state == 3) ? 1 : 0);
        check("ss_ramp", ss_ramp, m_ramp);
        check("hs_on", hs_on, m_hs);
        check("ls_on", ls_on, m_ls);
        check("overlap", hs_on & ls_on, 0);
    endtask

    task automatic step();
        @(posedge CELCLK);
        model_clock();
        #1;
        compare();
    endtask

    initial begin
        model_reset();
        #12;
        compare();
        @(posedge CELCLK);
        #1 CELRSTB = 1'b1;

        // soft-start to RUN
        en = 1'b1; pgood_in = 1'b1;
        step();
        check("ss_entry", o_state, 1);
        repeat (SS) step();
        check("run_reached", o_state, 2);
        check("run_ramp", ss_ramp, 8'hFF);

        // clean pwm edges, then toggles faster than dead-time
        pwm = 1'b1; repeat (8) step();
        check("hs_after_dt", hs_on, 1);
        pwm = 1'b0; repeat (8) step();
        check("ls_after_dt", ls_on, 1);
        for (int i = 0; i < 12; i++) begin
            pwm = ~pwm;
            repeat (2) step();
        end

        // ocp has priority over en=0
        pwm = 1'b1; repeat (8) step();
        ocp = 1'b1; en = 1'b0;
        step();
        check("ocp_fault", fault, 1);
        ocp = 1'b0;
        step();
        check("fault_exit", o_state, 0);

        // ocp pulse with en held high
        en = 1'b1; pwm = 1'b0;
        repeat (SS + 10) step();
        ocp = 1'b1; step();
        ocp = 1'b0;
        repeat (RT + 4) step();
        en = 1'b0; repeat (2) step();

        // randomized operation
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            en       = ($urandom_range(0, 599) != 0);
            pgood_in = ($urandom_range(0, 799) != 0);
            ocp      = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 5) == 0) pwm = ~pwm;
            step();
        end

        // async reset mid soft-start with high side on
        ocp = 1'b0; en = 1'b0; pgood_in = 1'b1; pwm = 1'b0;
        repeat (2) step();
        en = 1'b1; pwm = 1'b1;
        repeat (20) step();
        check("hs_before_rst", hs_on, 1);
        #2 CELRSTB = 1'b0;
        #1;
        check("rst_hs", hs_on, 0);
        check("rst_ls", ls_on, 0);
        check("rst_state", o_state, 0);
        check("rst_ramp", ss_ramp, 0);
        check("rst_fault", fault, 0);
        model_reset();
        @(posedge CELCLK);
        #1 CELRSTB = 1'b1;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stepdown_corestate_seq.md
STEPDOWN_CORESTATE_SEQ -- requirements
Module: stepdown_corestate_seq

Interface
REQ-001 Parameter SS_CYCLES, default 1024: soft-start length in clocks; SHALL be a power of two and at least 256.
REQ-002 Parameter DT_CYCLES, default 4: dead-time in clocks, range 1..15.
REQ-003 Parameter RETRY_CYCLES, default 4096: fault retry delay in clocks; used only under REQ-027.
REQ-004 CELCLK  in  1  single clock, all state on rising edge.
REQ-005 CELRSTB  in  1  reset, asynchronous assert, active-low.
REQ-006 CELV  in  1  supply pin; CELG  in  1  ground pin; SUB  in  1  substrate pin; no logic function.
REQ-007 en  in  1  converter enable.
REQ-008 pgood_in  in  1  supply-OK, high = input rail above UVLO.
REQ-009 ocp  in  1  overcurrent flag, synchronous to CELCLK.
REQ-010 pwm  in  1  raw PWM request, high = high-side requested.
REQ-011 hs_on  out  1  high-side gate command; drives the downstream 5V inverter input.
REQ-012 ls_on  out  1  low-side gate command.
REQ-013 o_state  out  2  state code: OFF=0, SOFTSTART=1, RUN=2, FAULT=3.
REQ-014 ss_ramp  out  8  soft-start reference level.
REQ-015 fault  out  1  high while in FAULT.

Function
REQ-016 State register SHALL be a 4-state FSM (OFF, SOFTSTART, RUN, FAULT); all outputs registered.
REQ-017 OFF->SOFTSTART when en=1 and pgood_in=1; the ss counter clears on entry.
REQ-018 SOFTSTART: the ss counter increments each cycle; the state SHALL move to RUN on the cycle after the counter equals SS_CYCLES-1.
REQ-019 In SOFTSTART or RUN: ocp=1 -> FAULT, with priority over the en/pgood_in exit; else en=0 or pgood_in=0 -> OFF.
REQ-020 FAULT: exit only to OFF when en=0 (default build); ocp has no further effect.
REQ-021 ss_ramp SHALL be ss_cnt[log2(SS_CYCLES)-1 -: 8] in SOFTSTART, 8'hFF in RUN, and 8'h00 in OFF and FAULT.
REQ-022 Gated request gp = pwm AND (state is SOFTSTART or RUN).
REQ-023 On any gp edge, both gates SHALL be 0 for exactly DT_CYCLES clocks; after that, hs_on=gp and ls_on=!gp.
REQ-024 A gp toggle during dead-time SHALL restart the dead-time count; hs_on and ls_on SHALL never be 1 together.
REQ-025 Leaving SOFTSTART/RUN SHALL force hs_on=ls_on=0 on the next cycle, with no dead-time wait; in OFF and FAULT both gates stay 0.

Reset
REQ-026 While CELRSTB=0: state=OFF, hs_on=0, ls_on=0, o_state=0, ss_ramp=0, fault=0, all counters 0; reset mid-operation SHALL drop the gates in the same cycle (asynchronous).

Configuration
REQ-027 Macro STEPDOWN_AUTORETRY_EN: when defined, FAULT counts RETRY_CYCLES clocks, then goes to SOFTSTART if en=1 and pgood_in=1, else to OFF; en=0 during the count -> OFF immediately. When undefined, REQ-020 applies and the retry counter is absent.

Structure
REQ-028 Package stepdown_pkg SHALL hold the state enum typedef (2-bit) and the SS_RAMP_W=8 constant.
REQ-029 Sub-module stepdown_deadtime (inputs gp and force_off; outputs hs_on and ls_on; counter width 4) SHALL implement REQ-023 to REQ-025.

Verification (SS_CYCLES=256, DT_CYCLES=4, RETRY_CYCLES=16)
REQ-030 Reset, then en=1, pgood_in=1 -> o_state=1 one cycle later; o_state=2 after 256 more cycles; ss_ramp=8'hFF in RUN.
REQ-031 In RUN, pwm 0->1 -> ls_on=0 next cycle, both 0 for 4 cycles, then hs_on=1; repeat for 1->0.
REQ-032 In RUN, pwm toggles at 2-cycle intervals -> both gates stay 0 throughout and are never high together.
REQ-033 ocp=1 together with en=0 in RUN -> o_state=3, fault=1, gates 0; then en=0 -> o_state=0.
REQ-034 With STEPDOWN_AUTORETRY_EN defined: ocp pulse, en held at 1 -> FAULT for 16 cycles, then o_state=1.
REQ-035 CELRSTB low mid-SOFTSTART with hs_on=1 -> hs_on=0 asynchronously, o_state=0, ss_ramp=0.
